router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkg.sv | 29 ++
 rtl/router_pkt_tx.sv | 125 ++++++++++++
 tb/tb_router_pkt_tx.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
// Packet on the wire: header {len, addr}, len payload bytes, one parity byte.
package router_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PLD  = 2'd2,
        PAR  = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } pkt_hdr_t;

    // A request is only sendable to a real port with a non-empty payload.
    function automatic logic cfg_valid(input logic [ADDR_W-1:0] addr,
                                       input logic [LEN_W-1:0]  len);
        return (addr != ADDR_INVALID) && (len != '0);
    endfunction

endpackage

// File: rtl/router_pkt_tx.sv
// Serialises one packet (header, payload popped from a show-ahead FIFO, parity)
// towards the router, honouring busy backpressure on every byte.
module router_pkt_tx
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  payload_len,
    input  logic              corrupt_parity,
    input  logic [DATA_W-1:0] pld_data,
    output logic              pld_req,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_in,
    output logic              tx_active,
    output logic              tx_done,
    output logic              cfg_err
);

    tx_state_e         state_q,   state_d;
    logic [LEN_W-1:0]  count_q,   count_d;
    logic [DATA_W-1:0] parity_q,  parity_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              corrupt_q, corrupt_d;
    logic              valid_q,   valid_d;
    logic              active_q,  active_d;
    logic              done_q,    done_d;
    logic              err_q,     err_d;
    logic              pop_c;
    pkt_hdr_t          hdr_c;

    // Next-state and datapath decode; pop_c is the only combinational output.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        parity_d  = parity_q;
        data_d    = data_q;
        corrupt_d = corrupt_q;
        valid_d   = valid_q;
        active_d  = active_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        pop_c     = 1'b0;
        hdr_c     = '{len: payload_len, addr: dest_addr};

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_valid(dest_addr, payload_len)) begin
                        state_d   = HDR;
                        count_d   = payload_len;
                        corrupt_d = corrupt_parity;
                        data_d    = hdr_c;
                        parity_d  = hdr_c;
                        valid_d   = 1'b1;
                        active_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HDR, PLD: begin
                // The byte on data_in is consumed; replace it with the next one.
                if (!busy) begin
                    if (count_q != '0) begin
                        pop_c    = 1'b1;
                        data_d   = pld_data;
                        parity_d = parity_q ^ pld_data;
                        count_d  = count_q - LEN_W'(1);
                        state_d  = PLD;
                    end else begin
                        data_d  = corrupt_q ? ~parity_q : parity_q;
                        valid_d = 1'b0;
                        state_d = PAR;
                    end
                end
            end
            PAR: begin
                if (!busy) begin
                    state_d  = IDLE;
                    data_d   = '0;
                    done_d   = 1'b1;
                    active_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            count_q   <= '0;
            parity_q  <= '0;
            data_q    <= '0;
            corrupt_q <= 1'b0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            parity_q  <= parity_d;
            data_q    <= data_d;
            corrupt_q <= corrupt_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign pld_req   = pop_c;
    assign pkt_valid = valid_q;
    assign data_in   = data_q;
    assign tx_active = active_q;
    assign tx_done   = done_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomised and directed checks of router_pkt_tx against a byte-stream model.
module tb_router_pkt_tx;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] payload_len;
    logic       corrupt_parity;
    logic [7:0] pld_data;
    logic       pld_req;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       tx_active;
    logic       tx_done;
    logic       cfg_err;

    router_pkt_tx dut (
        .clock          (clock),
        .resetn         (resetn),
        .start          (start),
        .dest_addr      (dest_addr),
        .payload_len    (payload_len),
        .corrupt_parity (corrupt_parity),
        .pld_data       (pld_data),
        .pld_req        (pld_req),
        .busy           (busy),
        .pkt_valid      (pkt_valid),
        .data_in        (data_in),
        .tx_active      (tx_active),
        .tx_done        (tx_done),
        .cfg_err        (cfg_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: the whole expected packet as a list of bytes plus a position in it.
    logic       m_active;
    int         m_idx;
    int         m_len;
    logic [7:0] m_stream[$];
    logic [7:0] m_pay[$];
    logic [7:0] next_pay[$];
    logic       m_done;
    logic       m_err;

    int n_vec;
    int n_err;
    int done_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_idx    = 0;
        m_len    = 0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        m_stream = {};
        m_pay    = {};
    endtask

    task automatic model_build(input logic [1:0] a, input logic [5:0] l, input logic c);
        logic [7:0] par;
        logic [7:0] b;
        m_len    = int'(l);
        m_pay    = {};
        m_stream = {};
        par      = {l, a};
        m_stream.push_back(par);
        for (int i = 0; i < m_len; i++) begin
            if (next_pay.size() != 0) b = next_pay.pop_front();
            else                      b = 8'($urandom);
            m_pay.push_back(b);
            m_stream.push_back(b);
            par = par ^ b;
        end
        m_stream.push_back(c ? ~par : par);
        m_idx    = 0;
        m_active = 1'b1;
    endtask

    // One clock: drive at negedge, check outputs, advance the model at posedge.
    task automatic cycle(input logic b, input logic st);
        logic [7:0] e_data;
        logic       e_valid;
        logic       e_req;
        logic [1:0] c_addr;
        logic [5:0] c_len;
        logic       c_corr;
        @(negedge clock);
        busy     = b;
        start    = st;
        pld_data = (m_active && m_idx < m_len) ? m_pay[m_idx] : 8'($urandom);
        #1;
        e_data  = m_active ? m_stream[m_idx] : 8'h00;
        e_valid = m_active && (m_idx <= m_len);
        e_req   = m_active && !b && (m_idx < m_len);
        check_eq("data_in",   32'(data_in),   32'(e_data));
        check_eq("pkt_valid", 32'(pkt_valid), 32'(e_valid));
        check_eq("tx_active", 32'(tx_active), 32'(m_active));
        check_eq("tx_done",   32'(tx_done),   32'(m_done));
        check_eq("cfg_err",   32'(cfg_err),   32'(m_err));
        check_eq("pld_req",   32'(pld_req),   32'(e_req));
        if (tx_done) done_seen++;
        c_addr = dest_addr;
        c_len  = payload_len;
        c_corr = corrupt_parity;
        @(posedge clock);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!m_active) begin
            if (st) begin
                if (c_addr != 2'b11 && c_len != 6'd0) model_build(c_addr, c_len, c_corr);
                else                                  m_err = 1'b1;
            end
        end else if (!b) begin
            m_idx++;
            if (m_idx == m_len + 2) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] a, input logic [5:0] l, input logic c);
        dest_addr      = a;
        payload_len    = l;
        corrupt_parity = c;
    endtask

    // Asynchronous reset pulse away from any clock edge.
    task automatic do_reset();
        #3;
        resetn = 1'b0;
        #1;
        check_eq("rst_data_in",   32'(data_in),   32'h0);
        check_eq("rst_pkt_valid", 32'(pkt_valid), 32'h0);
        check_eq("rst_tx_active", 32'(tx_active), 32'h0);
        check_eq("rst_pld_req",   32'(pld_req),   32'h0);
        check_eq("rst_tx_done",   32'(tx_done),   32'h0);
        check_eq("rst_cfg_err",   32'(cfg_err),   32'h0);
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        int d0;
        n_vec     = 0;
        n_err     = 0;
        done_seen = 0;
        next_pay  = {};
        model_reset();
        resetn   = 1'b0;
        start    = 1'b0;
        busy     = 1'b0;
        pld_data = 8'h00;
        set_cfg(2'd0, 6'd0, 1'b0);
        #12;
        check_eq("init_data_in",   32'(data_in),   32'h0);
        check_eq("init_pkt_valid", 32'(pkt_valid), 32'h0);
        check_eq("init_tx_active", 32'(tx_active), 32'h0);
        check_eq("init_pld_req",   32'(pld_req),   32'h0);
        @(negedge clock);
        resetn = 1'b1;

        // Reference packet, then the same with inverted parity.
        for (int k = 0; k < 2; k++) begin
            set_cfg(2'd1, 6'd3, k[0]);
            next_pay = '{8'h11, 8'h22, 8'h33};
            cycle(1'b0, 1'b1);
            for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
        end

        // Four-cycle stall while the second payload byte is on the bus.
        set_cfg(2'd1, 6'd3, 1'b0);
        next_pay = '{8'h11, 8'h22, 8'h33};
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);

        // Rejected configurations.
        set_cfg(2'd3, 6'd3, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        set_cfg(2'd1, 6'd0, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);

        // Reset in the middle of a long packet, then a fresh one.
        set_cfg(2'd2, 6'd9, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        do_reset();
        set_cfg(2'd2, 6'd2, 1'b1);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);

        // Back-to-back single-byte packets with start held high.
        set_cfg(2'd0, 6'd1, 1'b0);
        d0 = done_seen;
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check_eq("b2b_done_count", 32'(done_seen - d0), 32'd2);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);

        // Random traffic: configs, backpressure and start requests all vary.
        for (int i = 0; i < 3000; i++) begin
            set_cfg(2'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) == 0) ? 6'd0 :
                    ($urandom_range(0, 19) == 0) ? 6'd63 : 6'($urandom_range(1, 12)),
                    1'($urandom_range(0, 1)));
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0);
        end
        for (int i = 0; i < 80; i++) cycle(1'b0, 1'b0);
        check_eq("drain_idle", 32'(tx_active), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
